// File: rtl/uart_frame_checker.sv
// UART receive-path frame checker.
// Checks the start bit, the parity bit (five modes) and one or two stop bits,
// and recognises break frames. Each checked frame goes into a single-entry
// output buffer. A frame that arrives while the buffer is full and not being
// drained is an overrun. Saturating counters and sticky flags record errors.
module uart_frame_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_valid,
  input  logic              start_bit,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_bit,
  input  logic [1:0]        stop_bits,
  input  logic [2:0]        parity_mode,
  input  logic              stop2,
  input  logic              clear_stats,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_err,
  output logic [4:0]        sticky_err,
  output logic [CNT_W-1:0]  parity_err_cnt,
  output logic [CNT_W-1:0]  framing_err_cnt,
  output logic [CNT_W-1:0]  overrun_cnt,
  output logic [CNT_W-1:0]  break_cnt,
  output logic              dbg_state
);

  // Output handshake: a frame transfers on any cycle where out_valid and
  // out_ready are both 1. While out_valid is 1, out_data and out_err hold
  // steady until that transfer. out_ready may rise before out_valid.
  // out_valid comes straight from the state register, so there is no
  // combinational path from out_ready to out_valid.
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [3:0]          err_q, err_d;
  logic [4:0]          sticky_q, sticky_d;
  logic [CNT_W-1:0]    par_cnt_q, par_cnt_d;
  logic [CNT_W-1:0]    frm_cnt_q, frm_cnt_d;
  logic [CNT_W-1:0]    ovr_cnt_q, ovr_cnt_d;
  logic [CNT_W-1:0]    brk_cnt_q, brk_cnt_d;

  logic                par_en, exp_par, par_err, start_err, stop_err, brk;
  logic [DATA_W-1:0]   new_data;
  logic [3:0]          new_err;
  logic                load, overrun;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Evaluate the incoming frame against the mode settings sampled this cycle.
  always_comb begin
    par_en  = 1'b0;
    exp_par = 1'b0;
    case (parity_mode)
      3'b001:  begin par_en = 1'b1; exp_par = ~^data_in; end
      3'b010:  begin par_en = 1'b1; exp_par = ^data_in;  end
      3'b100:  begin par_en = 1'b1; exp_par = 1'b1;      end
      3'b101:  begin par_en = 1'b1; exp_par = 1'b0;      end
      default: begin par_en = 1'b0; exp_par = 1'b0;      end
    endcase
    par_err   = par_en & (exp_par ^ parity_bit);
    start_err = start_bit;
    stop_err  = ~stop_bits[0] | (stop2 & ~stop_bits[1]);
    // A break holds the line low for the whole frame, including every bit
    // that is checked.
    brk = ~start_bit & ~(|data_in) & ~(par_en & parity_bit) &
          ~stop_bits[0] & ~(stop2 & stop_bits[1]);
    if (brk) begin
      new_data = '0;
      new_err  = 4'b1000;
    end else begin
      new_data = data_in;
      new_err  = {1'b0, stop_err, start_err, par_err};
    end
  end

  // Buffer FSM: decide load / overrun / drain and the next buffer contents.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    load    = 1'b0;
    overrun = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (frame_valid) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (frame_valid && out_ready) begin
          load = 1'b1;
        end else if (frame_valid) begin
          overrun = 1'b1;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (load) begin
      data_d = new_data;
      err_d  = new_err;
    end
  end

  // Statistics: saturating counters and sticky flags. A clear wins over an
  // increment or a sticky set in the same cycle.
  always_comb begin
    par_cnt_d = par_cnt_q;
    frm_cnt_d = frm_cnt_q;
    ovr_cnt_d = ovr_cnt_q;
    brk_cnt_d = brk_cnt_q;
    sticky_d  = sticky_q;
    if (load && new_err[0])                par_cnt_d = sat_inc(par_cnt_q);
    if (load && (new_err[1] || new_err[2])) frm_cnt_d = sat_inc(frm_cnt_q);
    if (load && new_err[3])                brk_cnt_d = sat_inc(brk_cnt_q);
    if (overrun)                           ovr_cnt_d = sat_inc(ovr_cnt_q);
    if (load)    sticky_d[3:0] = sticky_q[3:0] | new_err;
    if (overrun) sticky_d[4]   = 1'b1;
    if (clear_stats) begin
      par_cnt_d = '0;
      frm_cnt_d = '0;
      ovr_cnt_d = '0;
      brk_cnt_d = '0;
      sticky_d  = '0;
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      data_q    <= '0;
      err_q     <= '0;
      sticky_q  <= '0;
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
      ovr_cnt_q <= '0;
      brk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      par_cnt_q <= par_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      ovr_cnt_q <= ovr_cnt_d;
      brk_cnt_q <= brk_cnt_d;
    end
  end

  assign out_valid       = (state_q == ST_FULL);
  assign out_data        = data_q;
  assign out_err         = err_q;
  assign sticky_err      = sticky_q;
  assign parity_err_cnt  = par_cnt_q;
  assign framing_err_cnt = frm_cnt_q;
  assign overrun_cnt     = ovr_cnt_q;
  assign break_cnt       = brk_cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_uart_frame_checker.sv
// Bench for uart_frame_checker (DATA_W=8, CNT_W=2): table of single frames,
// then hand sequences for overrun, saturation, clear priority and reset.
module tb_uart_frame_checker;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n, frame_valid, start_bit, parity_bit, stop2;
  logic          clear_stats, out_ready, out_valid, dbg_state;
  logic [DW-1:0] data_in, out_data;
  logic [1:0]    stop_bits;
  logic [2:0]    parity_mode;
  logic [3:0]    out_err;
  logic [4:0]    sticky_err;
  logic [CW-1:0] parity_err_cnt, framing_err_cnt, overrun_cnt, break_cnt;

  int n_vec = 0;
  int n_bad = 0;

  uart_frame_checker #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .frame_valid(frame_valid),
    .start_bit(start_bit), .data_in(data_in), .parity_bit(parity_bit),
    .stop_bits(stop_bits), .parity_mode(parity_mode), .stop2(stop2),
    .clear_stats(clear_stats), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .sticky_err(sticky_err),
    .parity_err_cnt(parity_err_cnt), .framing_err_cnt(framing_err_cnt),
    .overrun_cnt(overrun_cnt), .break_cnt(break_cnt), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic          start;
    logic [DW-1:0] data;
    logic          par;
    logic [1:0]    stop;
    logic [2:0]    mode;
    logic          s2;
    logic [DW-1:0] exp_data;
    logic [3:0]    exp_err;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic st, input logic [DW-1:0] d, input logic p,
                           input logic [1:0] sb, input logic [2:0] m, input logic s2);
    start_bit   = st;
    data_in     = d;
    parity_bit  = p;
    stop_bits   = sb;
    parity_mode = m;
    stop2       = s2;
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic [CW-1:0] m_par, m_frm, m_brk;
  logic [4:0]    m_sticky;

  initial begin
    // Hand-computed table: start, data, parity, stop, mode, stop2, exp data, exp err
    tbl[0]  = '{1'b0, 8'h55, 1'b1, 2'b01, 3'b001, 1'b0, 8'h55, 4'b0000}; // good, odd
    tbl[1]  = '{1'b0, 8'h07, 1'b0, 2'b01, 3'b001, 1'b0, 8'h07, 4'b0000}; // odd
    tbl[2]  = '{1'b0, 8'h07, 1'b0, 2'b01, 3'b010, 1'b0, 8'h07, 4'b0001}; // even
    tbl[3]  = '{1'b0, 8'h07, 1'b0, 2'b01, 3'b100, 1'b0, 8'h07, 4'b0001}; // mark
    tbl[4]  = '{1'b0, 8'h07, 1'b0, 2'b01, 3'b101, 1'b0, 8'h07, 4'b0000}; // space
    tbl[5]  = '{1'b0, 8'h07, 1'b0, 2'b01, 3'b011, 1'b0, 8'h07, 4'b0000}; // none
    tbl[6]  = '{1'b0, 8'h10, 1'b0, 2'b01, 3'b000, 1'b1, 8'h10, 4'b0100}; // 2nd stop bad
    tbl[7]  = '{1'b0, 8'h10, 1'b0, 2'b01, 3'b000, 1'b0, 8'h10, 4'b0000}; // 2nd stop ignored
    tbl[8]  = '{1'b1, 8'h10, 1'b0, 2'b00, 3'b000, 1'b0, 8'h10, 4'b0110}; // start+stop
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 2'b00, 3'b010, 1'b0, 8'h00, 4'b1000}; // break, even
    tbl[10] = '{1'b0, 8'h00, 1'b1, 2'b00, 3'b000, 1'b1, 8'h00, 4'b1000}; // break, parity ignored
    tbl[11] = '{1'b0, 8'h00, 1'b1, 2'b00, 3'b010, 1'b0, 8'h00, 4'b0101}; // parity 1 -> no break
    tbl[12] = '{1'b0, 8'hFF, 1'b1, 2'b11, 3'b110, 1'b1, 8'hFF, 4'b0000}; // 11x none
    tbl[13] = '{1'b1, 8'h01, 1'b1, 2'b01, 3'b001, 1'b0, 8'h01, 4'b0011}; // start+parity

    // Reset
    reset_n = 1'b0; frame_valid = 1'b0; clear_stats = 1'b0; out_ready = 1'b0;
    set_frame(1'b0, '0, 1'b0, 2'b11, 3'b000, 1'b0);
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", out_err, 0);
    chk("rst_sticky", sticky_err, 0);
    chk("rst_cnts", {parity_err_cnt, framing_err_cnt, overrun_cnt, break_cnt}, 0);
    reset_n = 1'b1;
    tick();

    // Table vectors with a running counter/sticky model
    m_par = '0; m_frm = '0; m_brk = '0; m_sticky = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_frame(tbl[i].start, tbl[i].data, tbl[i].par, tbl[i].stop, tbl[i].mode, tbl[i].s2);
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      if (tbl[i].exp_err[0]) m_par = sat(m_par);
      if (tbl[i].exp_err[1] | tbl[i].exp_err[2]) m_frm = sat(m_frm);
      if (tbl[i].exp_err[3]) m_brk = sat(m_brk);
      m_sticky[3:0] = m_sticky[3:0] | tbl[i].exp_err;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_data", i), out_data, tbl[i].exp_data);
      chk($sformatf("v%0d_err", i), out_err, tbl[i].exp_err);
      chk($sformatf("v%0d_par_cnt", i), parity_err_cnt, m_par);
      chk($sformatf("v%0d_frm_cnt", i), framing_err_cnt, m_frm);
      chk($sformatf("v%0d_brk_cnt", i), break_cnt, m_brk);
      chk($sformatf("v%0d_sticky", i), sticky_err, m_sticky);
      tick();
      chk($sformatf("v%0d_drain", i), out_valid, 0);
    end

    // Overrun: A1 held, B2 dropped, then C3 loaded alongside ready
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    out_ready = 1'b0;
    set_frame(1'b0, 8'hA1, 1'b0, 2'b01, 3'b000, 1'b0);
    frame_valid = 1'b1;
    tick();
    chk("ovr_a1_data", out_data, 8'hA1);
    set_frame(1'b0, 8'hB2, 1'b0, 2'b00, 3'b010, 1'b1);
    tick();
    frame_valid = 1'b0;
    chk("ovr_hold_data", out_data, 8'hA1);
    chk("ovr_hold_err", out_err, 4'b0000);
    chk("ovr_cnt", overrun_cnt, 1);
    chk("ovr_sticky", sticky_err, 5'b10000);
    chk("ovr_frm_cnt", framing_err_cnt, 0);
    tick();
    chk("ovr_still_valid", out_valid, 1);
    chk("ovr_still_data", out_data, 8'hA1);
    out_ready = 1'b1;
    set_frame(1'b0, 8'hC3, 1'b0, 2'b01, 3'b000, 1'b0);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("c3_data", out_data, 8'hC3);
    chk("c3_valid", out_valid, 1);
    chk("c3_ovr_cnt", overrun_cnt, 1);
    tick();
    chk("c3_drain", out_valid, 0);

    // Saturation: five back-to-back parity errors into a 2-bit counter
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    set_frame(1'b0, 8'h07, 1'b0, 2'b01, 3'b010, 1'b0);
    frame_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat%0d_valid", i), out_valid, 1);
      chk($sformatf("sat%0d_err", i), out_err, 4'b0001);
      chk($sformatf("sat%0d_cnt", i), parity_err_cnt, (i < 3) ? i + 1 : 3);
    end
    chk("sat_ovr_cnt", overrun_cnt, 0);

    // Clear in the same cycle as an error load
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    frame_valid = 1'b0;
    chk("clr_par_cnt", parity_err_cnt, 0);
    chk("clr_sticky", sticky_err, 0);
    chk("clr_buf_valid", out_valid, 1);
    chk("clr_buf_err", out_err, 4'b0001);
    tick();

    // Reset while full aborts the held frame and ignores a frame in reset
    out_ready = 1'b0;
    set_frame(1'b0, 8'h5A, 1'b0, 2'b01, 3'b000, 1'b0);
    frame_valid = 1'b1;
    tick();
    chk("rf_valid", out_valid, 1);
    reset_n = 1'b0;
    set_frame(1'b1, 8'h33, 1'b1, 2'b00, 3'b010, 1'b1);
    tick();
    chk("rf_rst_valid", out_valid, 0);
    chk("rf_rst_data", out_data, 0);
    chk("rf_rst_err", out_err, 0);
    reset_n = 1'b1;
    frame_valid = 1'b0;
    tick();
    chk("rf_after_valid", out_valid, 0);
    chk("rf_after_cnts", {parity_err_cnt, framing_err_cnt, overrun_cnt, break_cnt}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
